msxbus_sequencer: RTL and testbench

Host-side transaction sequencer sitting directly upstream of the MSX bus I/O block. Accepts one MSX memory/I/O read or write request at a time and turns it into the chip-select/a0/md phase sequence that block samples on falling clock edges: address phase, control phase with strobes negated, strobe phase, wait-state extension, data capture, release. Returns read data, or a timeout error, on a single-cycle response strobe.

---
 rtl/msxbus_pkg.sv | 43 ++++
 rtl/msxbus_ctrlword.sv | 57 +++++
 rtl/msxbus_sequencer.sv | 128 ++++++++++++
 tb/tb_msxbus_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msxbus_pkg.sv
// Shared types and constants for the MSX bus transaction sequencer.
package msxbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_SAMPLE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // Bit positions of the control word driven while a0 = 1.
    localparam int RD_N    = 15;
    localparam int WR_N    = 14;
    localparam int MREQ_N  = 13;
    localparam int IORQ_N  = 12;
    localparam int SLOT_HI = 11;
    localparam int SLOT_LO = 10;
    localparam int RESET_N = 9;
    localparam int M1_N    = 8;

    // Upper control byte with every active-low control negated (reset_n = 1).
    localparam logic [7:0] IDLE_CTRL = 8'hFF;

    typedef struct packed {
        logic        write;
        logic        io;
        logic [1:0]  slot;
        logic        m1;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msxbus_ctrlword.sv
// Packs the latched request and current phase into the cs/a0/md word seen by
// the bus I/O block, which samples it on the falling edge after it settles.
module msxbus_ctrlword
    import msxbus_pkg::*;
(
    input  state_t      state,
    input  req_t        req,
    output logic        cs,
    output logic        a0,
    output logic [15:0] md_out,
    output logic        md_oe
);

    logic [15:0] ctrl_word;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        cs     = 1'b1;
        a0     = 1'b0;
        md_out = '0;
        md_oe  = 1'b0;

        ctrl_word                  = {IDLE_CTRL, (req.write ? req.wdata : 8'h00)};
        ctrl_word[MREQ_N]          = req.io;
        ctrl_word[IORQ_N]          = ~req.io;
        ctrl_word[SLOT_HI:SLOT_LO] = req.slot;
        ctrl_word[M1_N]            = ~(req.m1 & ~req.write);

        case (state)
            ST_ADDR: begin
                // Full address goes out, so the low byte is driven too.
                cs     = 1'b0;
                md_out = req.addr;
                md_oe  = 1'b1;
            end
            ST_SETUP, ST_RELEASE: begin
                cs     = 1'b0;
                a0     = 1'b1;
                md_out = ctrl_word;
                md_oe  = req.write;
            end
            ST_STROBE, ST_WAIT, ST_SAMPLE: begin
                cs     = 1'b0;
                a0     = 1'b1;
                md_out = ctrl_word;
                md_out[req.write ? WR_N : RD_N] = 1'b0;
                md_oe  = req.write;
            end
            ST_DONE: begin
                a0     = 1'b1;
                md_out = {IDLE_CTRL, 8'h00};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/msxbus_sequencer.sv
// Host-side MSX bus transaction sequencer: one request at a time, walked through
// address, setup, strobe, wait-extension, sample and release phases.
module msxbus_sequencer
    import msxbus_pkg::*;
#(
    parameter int STROBE_CYCLES = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int WAIT_TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [1:0]  req_slot,
    input  logic        req_m1,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        cs,
    output logic        a0,
    output logic [15:0] md_out,
    output logic        md_oe,
    input  logic [7:0]  md_in,
    input  logic        rwait
);

    localparam int CNT_W = $clog2(max_of3(STROBE_CYCLES, SETUP_CYCLES, WAIT_TIMEOUT)) + 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic [7:0]       rdata_q;

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register sees
        // pre-edge values; later assignments in the same pass override earlier ones.
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            rdata_q   <= 8'hFF;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'hFF;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q <= '{write: req_write, io: req_io, slot: req_slot,
                                   m1: req_m1, addr: req_addr, wdata: req_wdata};
                        req_ready <= 1'b0;
                        err_q     <= 1'b0;
                        rdata_q   <= 8'hFF;
                        cnt       <= '0;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: state <= ST_SETUP;
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= ST_STROBE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    // rwait is only looked at here; the counter saturates into an abort.
                    if (rwait) begin
                        state <= ST_SAMPLE;
                    end else if (cnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (!req_q.write) rdata_q <= md_in;
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= rdata_q;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    msxbus_ctrlword u_ctrlword (
        .state  (state),
        .req    (req_q),
        .cs     (cs),
        .a0     (a0),
        .md_out (md_out),
        .md_oe  (md_oe)
    );

endmodule

// File: tb/tb_msxbus_sequencer.sv
// Scoreboard bench for msxbus_sequencer: a phase-level model predicts the bus
// word of every cycle and each response; a monitor compares them as they appear.
module tb_msxbus_sequencer;

    localparam int SETUP      = 2;
    localparam int STROBE     = 4;
    localparam int WT         = 1023;
    localparam int WAIT_START = 1 + SETUP + STROBE;

    typedef struct packed {
        logic        cs;
        logic        a0;
        logic [15:0] md;
        logic        oe;
        logic        rv;
    } bus_t;

    typedef struct {
        bit        write;
        bit        io;
        bit [1:0]  slot;
        bit        m1;
        bit [15:0] addr;
        bit [7:0]  wdata;
        bit [7:0]  rdata;
        int        w;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_io = 1'b0;
    logic [1:0]  req_slot = 2'b11;
    logic        req_m1 = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        cs;
    logic        a0;
    logic [15:0] md_out;
    logic        md_oe;
    logic [7:0]  md_in = '0;
    logic        rwait = 1'b1;

    bus_t       bus_q[$];
    logic [8:0] rsp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    msxbus_sequencer #(
        .STROBE_CYCLES (STROBE),
        .SETUP_CYCLES  (SETUP),
        .WAIT_TIMEOUT  (WT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_io    (req_io),
        .req_slot  (req_slot),
        .req_m1    (req_m1),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .cs        (cs),
        .a0        (a0),
        .md_out    (md_out),
        .md_oe     (md_oe),
        .md_in     (md_in),
        .rwait     (rwait)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bus_t mk(input logic c, input logic a, input logic [15:0] md,
                                input logic oe, input logic rv);
        return {c, a, md, oe, rv};
    endfunction

    function automatic bit is_timeout(input txn_t t);
        return t.w >= WT;
    endfunction

    function automatic int wait_cycles(input txn_t t);
        return is_timeout(t) ? WT : t.w + 1;
    endfunction

    // Cycles from the accept edge up to and including DONE.
    function automatic int txn_len(input txn_t t);
        return 1 + SETUP + STROBE + wait_cycles(t) + (is_timeout(t) ? 0 : 1) + 2;
    endfunction

    function automatic void push_expected(input txn_t t);
        logic [7:0] lo;
        logic       m1_n;
        logic [7:0] hold_hi;
        logic [7:0] strb_hi;
        lo      = t.write ? t.wdata : 8'h00;
        m1_n    = !(t.m1 && !t.write);
        hold_hi = {1'b1, 1'b1, t.io, !t.io, t.slot, 1'b1, m1_n};
        strb_hi = {t.write, !t.write, t.io, !t.io, t.slot, 1'b1, m1_n};
        bus_q.push_back(mk(1'b0, 1'b0, t.addr, 1'b1, 1'b0));
        for (int i = 0; i < SETUP; i++) bus_q.push_back(mk(1'b0, 1'b1, {hold_hi, lo}, t.write, 1'b0));
        for (int i = 0; i < STROBE + wait_cycles(t); i++)
            bus_q.push_back(mk(1'b0, 1'b1, {strb_hi, lo}, t.write, 1'b0));
        if (!is_timeout(t)) bus_q.push_back(mk(1'b0, 1'b1, {strb_hi, lo}, t.write, 1'b0));
        bus_q.push_back(mk(1'b0, 1'b1, {hold_hi, lo}, t.write, 1'b0));
        bus_q.push_back(mk(1'b1, 1'b1, 16'hFF00, 1'b0, 1'b1));
        rsp_q.push_back({is_timeout(t), (is_timeout(t) || t.write) ? 8'hFF : t.rdata});
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.write = 1'($urandom);
        t.io    = 1'($urandom);
        t.slot  = 2'($urandom);
        t.m1    = 1'($urandom);
        t.addr  = 16'($urandom);
        t.wdata = 8'($urandom);
        t.rdata = 8'($urandom);
        t.w     = $urandom_range(0, 8);
        return t;
    endfunction

    // Entered and left on a falling edge. reset_at >= 0 pulls reset at that cycle offset.
    task automatic run_txn(input txn_t t, input bit hold, input int reset_at, input bit expect_immediate);
        int guard;
        int len;
        guard = 0;
        len   = txn_len(t);
        req_valid = 1'b1;
        req_write = t.write;
        req_io    = t.io;
        req_slot  = t.slot;
        req_m1    = t.m1;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                check("accept_wait_expired", 32'(guard), 32'd0);
                req_valid = 1'b0;
                return;
            end
        end
        if (expect_immediate) check("b2b_accept_delay", 32'(guard), 32'd0);
        @(posedge clk);
        push_expected(t);
        @(negedge clk);
        for (int j = 0; j < len; j++) begin
            if (reset_at == j) begin
                reset_n   = 1'b0;
                req_valid = 1'b0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            rwait = (j >= WAIT_START + t.w) ? 1'b1 :
                    (j < WAIT_START) ? 1'($urandom) : 1'b0;
            md_in = (j == WAIT_START + 1 + t.w) ? t.rdata : ~t.rdata;
            // Fields wiggle while busy; none of this may be taken.
            req_valid = hold ? 1'b1 : 1'($urandom);
            req_write = 1'($urandom);
            req_io    = 1'($urandom);
            req_slot  = 2'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 8'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    // Monitor: per-cycle bus word plus response scoreboard.
    initial begin
        bit   rst_edge;
        bus_t act;
        bus_t exp;
        logic [8:0] rexp;
        forever begin
            @(posedge clk);
            rst_edge = !reset_n;
            if (rst_edge) begin
                bus_q.delete();
                rsp_q.delete();
            end
            @(negedge clk);
            act = {cs, a0, md_out, md_oe, rsp_valid};
            if (rst_edge) begin
                check("reset_bus", 32'(act), 32'(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0)));
                check("reset_ready", 32'(req_ready), 32'd0);
                check("reset_rsp", 32'({rsp_err, rsp_rdata}), 32'h0FF);
            end else if (bus_q.size() > 0) begin
                exp = bus_q.pop_front();
                check("bus_word", 32'(act), 32'(exp));
                check("busy_ready", 32'(req_ready), 32'd0);
            end else begin
                check("idle_bus", 32'(act), 32'(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0)));
                check("idle_ready", 32'(req_ready), 32'd1);
            end
            if (rsp_valid && rsp_q.size() > 0) begin
                rexp = rsp_q.pop_front();
                check("rsp_err_rdata", 32'({rsp_err, rsp_rdata}), 32'(rexp));
            end
        end
    end

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Memory read, zero wait.
        t = '{write: 0, io: 0, slot: 2'b10, m1: 0, addr: 16'h4000, wdata: 8'h00, rdata: 8'h5A, w: 0};
        run_txn(t, 1'b0, -1, 1'b0);
        repeat (2) @(negedge clk);

        // I/O write.
        t = '{write: 1, io: 1, slot: 2'b11, m1: 1, addr: 16'h0098, wdata: 8'hC3, rdata: 8'h00, w: 0};
        run_txn(t, 1'b0, -1, 1'b0);
        repeat (2) @(negedge clk);

        // Read with five wait-state cycles.
        t = '{write: 0, io: 0, slot: 2'b01, m1: 1, addr: 16'h8123, wdata: 8'h00, rdata: 8'hA7, w: 5};
        run_txn(t, 1'b0, -1, 1'b0);

        // Longest wait that still completes, then one that times out.
        t = '{write: 0, io: 1, slot: 2'b00, m1: 0, addr: 16'h00A8, wdata: 8'h00, rdata: 8'h3C, w: WT - 1};
        run_txn(t, 1'b0, -1, 1'b0);
        t = '{write: 0, io: 0, slot: 2'b10, m1: 0, addr: 16'hC000, wdata: 8'h00, rdata: 8'h99, w: WT};
        run_txn(t, 1'b0, -1, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in the middle of the strobe, then a normal request.
        t = '{write: 1, io: 0, slot: 2'b01, m1: 0, addr: 16'h1234, wdata: 8'h55, rdata: 8'h00, w: 0};
        run_txn(t, 1'b0, 1 + SETUP + 1, 1'b0);
        repeat (2) @(negedge clk);
        run_txn(rand_txn(), 1'b0, -1, 1'b0);

        // Back-to-back with req_valid held.
        for (int i = 0; i < 4; i++) run_txn(rand_txn(), 1'b1, -1, i > 0);
        repeat (3) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            run_txn(rand_txn(), 1'($urandom), -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
